// File: rtl/wav_ahb_pkg.sv
// wav_ahb_pkg: AHB-Lite encodings and master FSM states
// shared by the wav AHB master and its bench
package wav_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } ahb_state_t;

endpackage

// File: rtl/wav_ahb_master.sv
// wav_ahb_master: single-outstanding AHB-Lite initiator
// word-sized SINGLE transfers, all outputs registered
module wav_ahb_master
  import wav_ahb_pkg::*;
#(
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int TOUT_CYC = 255
) (
  input  logic              i_hclk,
  input  logic              i_hreset,
  input  logic              i_req,
  input  logic              i_write,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [DWIDTH-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_ack,
  output logic [DWIDTH-1:0] o_rdata,
  output logic              o_error,
  output logic              o_timeout,
  output logic [AWIDTH-1:0] o_haddr,
  output logic              o_hwrite,
  output logic [1:0]        o_htrans,
  output logic [2:0]        o_hsize,
  output logic [2:0]        o_hburst,
  output logic [DWIDTH-1:0] o_hwdata,
  input  logic              i_hready,
  input  logic [DWIDTH-1:0] i_hrdata,
  input  logic [1:0]        i_hresp
);

  localparam int CW = $clog2(TOUT_CYC + 1);
  localparam logic [CW-1:0] TLAST =
    CW'(TOUT_CYC - 1);

  ahb_state_t        state;
  logic [CW-1:0]     wcnt;
  logic [DWIDTH-1:0] wdata_q;

  assign o_hsize  = HSIZE_WORD;
  assign o_hburst = HBURST_SINGLE;

  // transfer FSM; haddr/hwrite double as the
  // captured request so later i_* changes are inert
  always_ff @(posedge i_hclk or negedge i_hreset) begin
    if (!i_hreset) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      wdata_q   <= '0;
      o_busy    <= 1'b0;
      o_ack     <= 1'b0;
      o_rdata   <= '0;
      o_error   <= 1'b0;
      o_timeout <= 1'b0;
      o_haddr   <= '0;
      o_hwrite  <= 1'b0;
      o_htrans  <= HTRANS_IDLE;
      o_hwdata  <= '0;
    end else begin
      o_ack   <= 1'b0;
      o_error <= 1'b0;
      o_rdata <= '0;
      unique case (state)
        ST_IDLE: begin
          if (i_req) begin
            o_haddr  <= i_addr;
            o_hwrite <= i_write;
            wdata_q  <= i_wdata;
            o_busy   <= 1'b1;
            o_htrans <= HTRANS_NONSEQ;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (i_hready) begin
            o_htrans <= HTRANS_IDLE;
            o_hwdata <= wdata_q;
            wcnt     <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (i_hready) begin
            o_ack    <= 1'b1;
            o_error  <= (i_hresp == HRESP_ERROR);
            o_rdata  <= o_hwrite ? '0 : i_hrdata;
            o_busy   <= 1'b0;
            o_hwdata <= '0;
            state    <= ST_IDLE;
          end else if (wcnt == TLAST) begin
            o_ack     <= 1'b1;
            o_error   <= 1'b1;
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            o_hwdata  <= '0;
            state     <= ST_IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
